// File: rtl/inst_fetch_resp.sv
// Instruction-fetch return path: issues PC-generator requests to memory, tags them with their PC,
// and buffers in-order responses for decode. Flushes discard in-flight fetches.
module inst_fetch_resp #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_en_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0]   DepthSum = DEPTH[CntW:0];
  localparam logic [CntW-1:0] DepthCnt = DEPTH[CntW-1:0];

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] dpc_q  [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];

  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PtrW-1:0] trptr_q, trptr_d, twptr_q, twptr_d;
  logic [CntW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;

  logic credit, accept, dropping, live_resp, fifo_push, fifo_pop;

  assign credit    = ({1'b0, cnt_q} + {1'b0, out_q}) < DepthSum;
  // Request and stall are qualified by reset so both read low while reset is held.
  assign mem_req_o  = rst_n & inst_en_i & credit & ~flush_i;
  assign mem_addr_o = pc_i;
  assign accept     = mem_req_o & mem_gnt_i;
  assign stallreq_o = rst_n & inst_en_i & ~accept & ~flush_i;

  assign dropping  = (drop_q != '0);
  assign live_resp = mem_rvalid_i & ~dropping;
  assign fifo_push = live_resp & ~flush_i;
  assign fifo_pop  = inst_valid_o & inst_ready_i & ~flush_i;

  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_valid_o ? data_q[rptr_q] : '0;
  assign inst_pc_o    = inst_valid_o ? dpc_q[rptr_q]  : '0;

  always_comb begin
    out_d   = out_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    trptr_d = trptr_q;
    twptr_d = twptr_q;

    if (accept)       out_d = out_d + CntW'(1);
    if (mem_rvalid_i) out_d = out_d - CntW'(1);

    if (flush_i) begin
      // drop + live - returning response: everything still in flight after this edge is stale.
      drop_d  = out_q - CntW'(mem_rvalid_i);
      cnt_d   = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      trptr_d = '0;
      twptr_d = '0;
    end else begin
      if (mem_rvalid_i && dropping) drop_d = drop_q - CntW'(1);
      if (accept)    twptr_d = twptr_q + PtrW'(1);
      if (live_resp) trptr_d = trptr_q + PtrW'(1);
      if (fifo_push) wptr_d  = wptr_q + PtrW'(1);
      if (fifo_pop)  rptr_d  = rptr_q + PtrW'(1);
      if (fifo_push && !fifo_pop) cnt_d = cnt_q + CntW'(1);
      if (!fifo_push && fifo_pop) cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      trptr_q <= '0;
      twptr_q <= '0;
    end else begin
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      trptr_q <= trptr_d;
      twptr_q <= twptr_d;
    end
  end

  // Storage needs no reset: outputs are masked by the valid count.
  always_ff @(posedge clk) begin
    if (accept) tag_q[twptr_q] <= pc_i;
    if (fifo_push) begin
      data_q[wptr_q] <= mem_rdata_i;
      dpc_q[wptr_q]  <= tag_q[trptr_q];
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && !fifo_pop && (cnt_q == DepthCnt)));
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp: stimulus pushes expected {pc, inst} into a scoreboard,
// a negedge monitor pops and compares on every decode handshake.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_en_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        stallreq_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_pc_o;
  logic        inst_ready_i = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  inst_fetch_resp #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_en_i    (inst_en_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .stallreq_o   (stallreq_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic en, input logic [31:0] pc, input logic gnt, input logic rv,
                     input logic [31:0] rd);
    inst_en_i    = en;
    pc_i         = pc;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
  endtask

  function automatic logic [31:0] dat(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic single_fetch(input string tag);
    tick(); set(1'b1, 32'h0, 1'b1, 1'b0, '0);
    #1;
    chk({tag, "_req"}, mem_req_o, 1);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_nostall"}, stallreq_o, 0);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'h0280_0000);
    push_exp(32'h0, 32'h0280_0000);
    tick(); set(1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk({tag, "_valid"}, inst_valid_o, 1);
    chk({tag, "_pc"}, inst_pc_o, 0);
    chk({tag, "_inst"}, inst_o, 32'h0280_0000);
    inst_ready_i = 1'b1;
    tick(); inst_ready_i = 1'b0;
    #1;
    chk({tag, "_drained"}, inst_valid_o, 0);
  endtask

  // Scoreboard monitor: compares the head on every consumed entry.
  always @(negedge clk) begin
    if (rst_n && inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual_pc=%0h required=none", inst_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_pc", inst_pc_o, e.pc);
        chk("pop_inst", inst_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", inst_pc_o, 0);
    tick(); rst_n = 1'b1;

    single_fetch("single");

    // Back-pressure: fill all four credits with decode stalled.
    tick(); set(1'b1, 32'h0, 1'b1, 1'b0, '0);
    tick(); set(1'b1, 32'h4, 1'b1, 1'b1, dat(32'h0));  push_exp(32'h0, dat(32'h0));
    tick(); set(1'b1, 32'h8, 1'b1, 1'b1, dat(32'h4));  push_exp(32'h4, dat(32'h4));
    tick(); set(1'b1, 32'hC, 1'b1, 1'b1, dat(32'h8));  push_exp(32'h8, dat(32'h8));
    tick(); set(1'b1, 32'h10, 1'b1, 1'b1, dat(32'hC)); push_exp(32'hC, dat(32'hC));
    #1;
    chk("bp_req_blocked", mem_req_o, 0);
    chk("bp_stall", stallreq_o, 1);
    tick(); set(1'b1, 32'h10, 1'b1, 1'b0, '0);
    #1;
    chk("bp_full_stall", stallreq_o, 1);
    chk("bp_full_valid", inst_valid_o, 1);
    chk("bp_head0", inst_pc_o, 32'h0);
    tick(); inst_ready_i = 1'b1;
    #1;
    chk("bp_pop_cycle_stall", stallreq_o, 1);
    tick(); inst_ready_i = 1'b0;
    #1;
    chk("bp_accept_req", mem_req_o, 1);
    chk("bp_accept_nostall", stallreq_o, 0);
    chk("bp_accept_addr", mem_addr_o, 32'h10);
    chk("bp_head4", inst_pc_o, 32'h4);
    tick(); set(1'b0, '0, 1'b0, 1'b1, dat(32'h10)); push_exp(32'h10, dat(32'h10));
    tick(); set(1'b0, '0, 1'b0, 1'b0, '0); inst_ready_i = 1'b1;
    repeat (4) tick();
    inst_ready_i = 1'b0;
    #1;
    chk("bp_drained", inst_valid_o, 0);

    // Grant stall.
    tick(); set(1'b1, 32'h20, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gs_stall", stallreq_o, 1);
      chk("gs_req", mem_req_o, 1);
      tick();
    end
    mem_gnt_i = 1'b1;
    #1;
    chk("gs_grant_nostall", stallreq_o, 0);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'h0BAD_0020); push_exp(32'h20, 32'h0BAD_0020);
    tick(); set(1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk("gs_valid", inst_valid_o, 1);
    inst_ready_i = 1'b1;
    tick(); inst_ready_i = 1'b0;
    #1;
    chk("gs_single_entry", inst_valid_o, 0);

    // Flush with two fetches in flight.
    tick(); set(1'b1, 32'h0, 1'b1, 1'b0, '0);
    tick(); set(1'b1, 32'h4, 1'b1, 1'b0, '0);
    tick(); set(1'b1, 32'h8, 1'b1, 1'b0, '0); flush_i = 1'b1;
    #1;
    chk("fl_no_req", mem_req_o, 0);
    chk("fl_no_stall", stallreq_o, 0);
    tick(); set(1'b1, 32'h1C00_0000, 1'b1, 1'b0, '0); flush_i = 1'b0;
    #1;
    chk("fl_target_req", mem_req_o, 1);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'hAAAA);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'hBBBB);
    #1;
    chk("fl_drop_a", inst_valid_o, 0);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'hCCCC); push_exp(32'h1C00_0000, 32'hCCCC);
    #1;
    chk("fl_drop_b", inst_valid_o, 0);
    tick(); set(1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk("fl_target_valid", inst_valid_o, 1);
    inst_ready_i = 1'b1;
    tick(); inst_ready_i = 1'b0;
    #1;
    chk("fl_single_entry", inst_valid_o, 0);

    // Flush coincident with a response while the FIFO holds data.
    tick(); set(1'b1, 32'h40, 1'b1, 1'b0, '0);
    tick(); set(1'b1, 32'h44, 1'b1, 1'b1, dat(32'h40));
    tick(); set(1'b1, 32'h48, 1'b1, 1'b0, '0);
    tick(); set(1'b1, 32'h4C, 1'b1, 1'b1, dat(32'h44)); flush_i = 1'b1;
    #1;
    chk("flr_pre_valid", inst_valid_o, 1);
    chk("flr_no_req", mem_req_o, 0);
    tick(); set(1'b1, 32'h80, 1'b1, 1'b0, '0); flush_i = 1'b0;
    #1;
    chk("flr_fifo_cleared", inst_valid_o, 0);
    chk("flr_target_req", mem_req_o, 1);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'hDEAD);
    tick(); set(1'b0, '0, 1'b0, 1'b1, 32'h8080); push_exp(32'h80, 32'h8080);
    #1;
    chk("flr_stale_dropped", inst_valid_o, 0);
    tick(); set(1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    chk("flr_target_valid", inst_valid_o, 1);
    inst_ready_i = 1'b1;
    tick(); inst_ready_i = 1'b0;
    #1;
    chk("flr_single_entry", inst_valid_o, 0);

    // Asynchronous reset in the middle of a burst.
    tick(); set(1'b1, 32'h100, 1'b1, 1'b0, '0);
    tick(); set(1'b1, 32'h104, 1'b1, 1'b1, dat(32'h100));
    tick(); set(1'b1, 32'h108, 1'b0, 1'b0, '0);
    #1;
    chk("ar_pre_stall", stallreq_o, 1);
    chk("ar_pre_valid", inst_valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", inst_valid_o, 0);
    chk("ar_req", mem_req_o, 0);
    chk("ar_stall", stallreq_o, 0);
    chk("ar_pc", inst_pc_o, 0);
    set(1'b0, '0, 1'b0, 1'b0, '0);
    tick(); tick(); rst_n = 1'b1;
    single_fetch("post_rst");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
